// File: rtl/assoc_cache.sv
// N-way set-associative write-through cache with tree-PLRU replacement and DMA bus yielding.
// Optional CACHE_BYPASS_EN adds a bypass input that skips lookup and allocation.
module assoc_cache #(
  parameter int WORD_SIZE = 16,
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef CACHE_BYPASS_EN
  input  logic                   bypass,
`endif
  input  logic                   bus_granted,
  input  logic                   readC,
  input  logic                   writeC,
  input  logic [WORD_SIZE-1:0]   address,
  input  logic [WORD_SIZE-1:0]   wdata,
  output logic [WORD_SIZE-1:0]   rdata,
  output logic                   readyC,
  output logic                   readM,
  output logic                   writeM,
  output logic [WORD_SIZE-1:0]   addressM,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  input  logic                   input_readyM,
  input  logic                   doneM,
  output logic [WORD_SIZE-1:0]   num_cache_access,
  output logic [WORD_SIZE-1:0]   num_cache_miss
);

  // state  | meaning
  // IDLE   | waiting for readC/writeC, latches request
  // TAG    | tag compare, hit/miss decision, victim selection
  // FILL   | line fetch from memory (yields to DMA)
  // WRITE  | write-through of updated line (yields to DMA)
  // DONE   | one-cycle readyC, PLRU update

  localparam int SETS      = 1 << SET_BITS;
  localparam int TAG_BITS  = WORD_SIZE - SET_BITS - 2;
  localparam int LINE_W    = 4 * WORD_SIZE;
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_BITS = (WAYS == 4) ? 3 : 1;

  typedef enum logic [2:0] {S_IDLE, S_TAG, S_FILL, S_WRITE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WORD_SIZE-1:0] addr_q, wdata_q, rdata_q, access_q, miss_q;
  logic                 is_write_q, bypass_q, bypass_in;
  logic [WAY_BITS-1:0]  way_q, hit_way, victim;
  logic [LINE_W-1:0]    line_q, hit_line, fill_line;
  logic                 hit, found_inv, fill_ack;

  logic [LINE_W-1:0]    data_mem [SETS][WAYS];
  logic [TAG_BITS-1:0]  tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]      valid_q  [SETS];
  logic [PLRU_BITS-1:0] plru_q   [SETS];

  logic [1:0]            offset;
  logic [SET_BITS-1:0]   index;
  logic [TAG_BITS-1:0]   tag;
  logic [WORD_SIZE-1:0]  line_addr;

`ifdef CACHE_BYPASS_EN
  assign bypass_in = bypass;
`else
  assign bypass_in = 1'b0;
`endif

  assign offset    = addr_q[1:0];
  assign index     = addr_q[SET_BITS+1:2];
  assign tag       = addr_q[WORD_SIZE-1:SET_BITS+2];
  assign line_addr = {addr_q[WORD_SIZE-1:2], 2'b00};
  assign fill_ack  = (state == S_FILL) && input_readyM && !bus_granted;

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0] off,
                                                   input logic [WORD_SIZE-1:0] w);
    logic [LINE_W-1:0] r;
    r = line;
    r[int'(off)*WORD_SIZE +: WORD_SIZE] = w;
    return r;
  endfunction

  // Tree encoding: a 0 bit points the victim at the left subtree.
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_BITS-1:0] p);
    logic [2:0] pp;
    int v;
    pp = 3'(p);
    v = 0;
    if (WAYS == 2) v = int'(pp[0]);
    else if (WAYS == 4) v = pp[0] ? (pp[2] ? 3 : 2) : (pp[1] ? 1 : 0);
    return WAY_BITS'(v);
  endfunction

  function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] p,
                                                      input logic [WAY_BITS-1:0] w);
    logic [2:0] pp;
    int wi;
    pp = 3'(p);
    wi = int'(w);
    if (WAYS == 2) pp[0] = (wi == 0);
    else if (WAYS == 4) begin
      pp[0] = (wi < 2);
      if (wi < 2) pp[1] = (wi == 0);
      else        pp[2] = (wi == 2);
    end
    return PLRU_BITS'(pp);
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[index][w] && (tag_mem[index][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  always_comb begin
    found_inv = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[index][w]) begin
        found_inv = 1'b1;
        victim    = WAY_BITS'(w);
      end
    end
    if (!found_inv) victim = plru_victim(plru_q[index]);
  end

  assign hit_line  = data_mem[index][hit_way];
  assign fill_line = is_write_q ? merge_word(mem_rdata, offset, wdata_q) : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    readyC    = 1'b0;
    readM     = 1'b0;
    writeM    = 1'b0;
    addressM  = '0;
    case (state)
      S_IDLE: if (readC || writeC) state_nxt = S_TAG;
      S_TAG: begin
        if (bypass_q)  state_nxt = is_write_q ? S_WRITE : S_FILL;
        else if (hit)  state_nxt = is_write_q ? S_WRITE : S_DONE;
        else           state_nxt = S_FILL;
      end
      S_FILL: begin
        addressM = line_addr;
        readM    = !bus_granted;
        if (input_readyM && !bus_granted) state_nxt = is_write_q ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        addressM = line_addr;
        writeM   = !bus_granted;
        if (doneM && !bus_granted) state_nxt = S_DONE;
      end
      S_DONE: begin
        readyC    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      bypass_q   <= 1'b0;
      way_q      <= '0;
      line_q     <= '0;
      rdata_q    <= '0;
      access_q   <= '0;
      miss_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (readC || writeC) begin
            addr_q     <= address;
            wdata_q    <= wdata;
            is_write_q <= writeC & ~readC;
            bypass_q   <= bypass_in;
          end
        end
        S_TAG: begin
          if (bypass_q) begin
            if (is_write_q) line_q <= merge_word('0, offset, wdata_q);
          end else begin
            access_q <= access_q + 1'b1;
            if (hit) begin
              way_q <= hit_way;
              if (is_write_q) line_q  <= merge_word(hit_line, offset, wdata_q);
              else            rdata_q <= hit_line[int'(offset)*WORD_SIZE +: WORD_SIZE];
            end else begin
              miss_q <= miss_q + 1'b1;
              way_q  <= victim;
            end
          end
        end
        S_FILL: begin
          if (fill_ack) begin
            if (is_write_q) line_q  <= fill_line;
            else            rdata_q <= mem_rdata[int'(offset)*WORD_SIZE +: WORD_SIZE];
            if (!bypass_q) valid_q[index][way_q] <= 1'b1;
          end
        end
        S_DONE: begin
          if (!bypass_q) plru_q[index] <= plru_touch(plru_q[index], way_q);
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == S_TAG && !bypass_q && hit && is_write_q)
      data_mem[index][hit_way] <= merge_word(hit_line, offset, wdata_q);
    if (fill_ack && !bypass_q) begin
      data_mem[index][way_q] <= fill_line;
      tag_mem[index][way_q]  <= tag;
    end
  end

  assign rdata            = rdata_q;
  assign mem_wdata        = line_q;
  assign num_cache_access = access_q;
  assign num_cache_miss   = miss_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: behavioural memory model plus a read-data scoreboard.
module tb_assoc_cache;

  logic        clk, reset, bus_granted, readC, writeC, input_readyM, doneM;
  logic [15:0] address, wdata, rdata, addressM, num_cache_access, num_cache_miss;
  logic        readyC, readM, writeM;
  logic [63:0] mem_rdata, mem_wdata;
`ifdef CACHE_BYPASS_EN
  logic        bypass;
`endif

  int checks = 0;
  int failures = 0;
  logic [63:0] mem_model [0:255];
  logic [15:0] sb_q [$];

  assoc_cache #(.WORD_SIZE(16), .WAYS(2), .SET_BITS(2)) dut (
    .clk(clk), .reset(reset),
`ifdef CACHE_BYPASS_EN
    .bypass(bypass),
`endif
    .bus_granted(bus_granted), .readC(readC), .writeC(writeC),
    .address(address), .wdata(wdata), .rdata(rdata), .readyC(readyC),
    .readM(readM), .writeM(writeM), .addressM(addressM),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .input_readyM(input_readyM), .doneM(doneM),
    .num_cache_access(num_cache_access), .num_cache_miss(num_cache_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request end to end; memory answers after lat cycles of readM/writeM.
  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input int lat, output int cyc, output logic saw_m);
    logic [63:0] exp_line;
    logic [15:0] exp_word;
    int fcnt, wcnt;
    logic done;
    exp_line = mem_model[a[9:2]];
    exp_line[int'(a[1:0])*16 +: 16] = d;
    if (!wr) sb_q.push_back(mem_model[a[9:2]][int'(a[1:0])*16 +: 16]);
    readC = !wr; writeC = wr; address = a; wdata = d;
    cyc = 0; fcnt = 0; wcnt = 0; done = 1'b0; saw_m = 1'b0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      input_readyM = 1'b0; doneM = 1'b0;
      if (readyC) begin
        done = 1'b1; readC = 1'b0; writeC = 1'b0;
        if (!wr && sb_q.size() != 0) begin
          exp_word = sb_q.pop_front();
          chk("rdata", rdata, exp_word);
        end
      end else if (readM) begin
        saw_m = 1'b1;
        chk("fill_addr", addressM, {a[15:2], 2'b00});
        fcnt++;
        if (fcnt >= lat) begin mem_rdata = mem_model[a[9:2]]; input_readyM = 1'b1; end
      end else if (writeM) begin
        chk("wr_addr", addressM, {a[15:2], 2'b00});
        chk("wr_line", mem_wdata, exp_line);
        wcnt++;
        if (wcnt >= lat) begin doneM = 1'b1; mem_model[a[9:2]] = exp_line; end
      end
    end
    if (!done) begin chk("req_timeout", done, 1'b1); readC = 1'b0; writeC = 1'b0; end
    @(posedge clk); #1;
    chk("readyC_pulse", readyC, 1'b0);
  endtask

  initial begin
    int cyc, n;
    logic sm;
    logic [15:0] ew;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 4; j++) mem_model[i][j*16 +: 16] = 16'hA000 + 16'(i*4 + j);
    mem_model[4] = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    reset = 1'b1; bus_granted = 1'b0; readC = 1'b0; writeC = 1'b0;
    address = '0; wdata = '0; mem_rdata = '0; input_readyM = 1'b0; doneM = 1'b0;
`ifdef CACHE_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readyC", readyC, 1'b0);
    chk("rst_readM", readM, 1'b0);
    chk("rst_writeM", writeM, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_addressM", addressM, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_access", num_cache_access, 16'h0);
    chk("rst_miss", num_cache_miss, 16'h0);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // cold miss then hit in the same line
    access(1'b0, 16'h0010, 16'h0, 2, cyc, sm);
    chk("t1_readM", sm, 1'b1);
    chk("t1_rdata", rdata, 16'h1111);
    chk("t1_access", num_cache_access, 16'd1);
    chk("t1_miss", num_cache_miss, 16'd1);
    access(1'b0, 16'h0013, 16'h0, 2, cyc, sm);
    chk("t2_no_fill", sm, 1'b0);
    chk("t2_latency", cyc, 2);
    chk("t2_rdata", rdata, 16'h4444);
    chk("t2_access", num_cache_access, 16'd2);
    chk("t2_miss", num_cache_miss, 16'd1);

    // three tags into set 0: LRU way holding 0x0050 is evicted
    access(1'b0, 16'h0010, 16'h0, 1, cyc, sm); chk("t3_hit_10", sm, 1'b0);
    access(1'b0, 16'h0050, 16'h0, 1, cyc, sm); chk("t3_miss_50", sm, 1'b1);
    chk("t3_miss_latency", cyc, 3);
    access(1'b0, 16'h0010, 16'h0, 1, cyc, sm); chk("t3_hit_10b", sm, 1'b0);
    access(1'b0, 16'h0090, 16'h0, 1, cyc, sm); chk("t3_miss_90", sm, 1'b1);
    access(1'b0, 16'h0010, 16'h0, 1, cyc, sm); chk("t3_rehit_10", sm, 1'b0);
    access(1'b0, 16'h0050, 16'h0, 1, cyc, sm); chk("t3_evicted_50", sm, 1'b1);
    chk("t3_miss", num_cache_miss, 16'd4);

    // write hit with write-through held for three cycles
    access(1'b1, 16'h0011, 16'hBEEF, 3, cyc, sm);
    chk("t4_write_no_fill", sm, 1'b0);
    chk("t4_write_latency", cyc, 5);
    access(1'b0, 16'h0011, 16'h0, 1, cyc, sm);
    chk("t4_read_hit", sm, 1'b0);
    chk("t4_rdata", rdata, 16'hBEEF);

    // DMA takes the bus mid-fill; a stray input_readyM is ignored
    ew = mem_model[8'h41][15:0];
    sb_q.push_back(ew);
    readC = 1'b1; address = 16'h0104; n = 0;
    while (!readM && n < 20) begin @(posedge clk); #1; n++; end
    chk("t5_fill_start", readM, 1'b1);
    @(posedge clk); #1;
    bus_granted = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_readM_blocked", readM, 1'b0);
      if (i == 2) mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      input_readyM = (i == 2);
      @(posedge clk); #1;
    end
    input_readyM = 1'b0;
    chk("t5_held", readyC, 1'b0);
    bus_granted = 1'b0;
    #1;
    chk("t5_readM_resume", readM, 1'b1);
    chk("t5_addressM", addressM, 16'h0104);
    mem_rdata = mem_model[8'h41];
    input_readyM = 1'b1;
    @(posedge clk); #1;
    input_readyM = 1'b0; readC = 1'b0;
    chk("t5_readyC", readyC, 1'b1);
    if (sb_q.size() != 0) begin
      ew = sb_q.pop_front();
      chk("t5_rdata", rdata, ew);
    end
    chk("t5_access", num_cache_access, 16'd11);
    chk("t5_miss", num_cache_miss, 16'd5);
    @(posedge clk); #1;

    // reset in the middle of a fill drops readM and clears the tags
    readC = 1'b1; address = 16'h0200; n = 0;
    while (!readM && n < 20) begin @(posedge clk); #1; n++; end
    chk("t6_fill_start", readM, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_readM_reset", readM, 1'b0);
    chk("t6_access_reset", num_cache_access, 16'd0);
    readC = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 16'h0013, 16'h0, 2, cyc, sm);
    chk("t6_miss_after_reset", sm, 1'b1);
    chk("t6_miss", num_cache_miss, 16'd1);
    chk("t6_access", num_cache_access, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
